led_pio_blink: RTL
==================

Name: led_pio_blink

Overview:
- Parametrised Avalon-MM output PIO for board LEDs; next generation of the single-register LED port.
- Adds atomic set/clear/toggle registers, a per-bit blink enable and a programmable blink prescaler.
- Sits between the Nios/Qsys interconnect (s1 slave) and the LED pins; out_port is driven from a register.

Parameters:
- DATA_WIDTH, 32, number of output bits, range 1..32.
- RESET_VALUE, 0, value of the DATA register after reset (low DATA_WIDTH bits).
- PRESC_WIDTH, 24, width of the blink prescaler and PERIOD register, range 1..32.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data; bits above the register width are ignored.
- readdata  out  32  combinational read data, zero-extended; valid whenever chipselect=1.
- out_port  out  DATA_WIDTH  registered LED drive.

Behaviour:
- Register map (word address, name, access):
  - 0 DATA, R/W.
  - 1 SET, W; reads 0.
  - 2 CLEAR, W; reads 0.
  - 3 TOGGLE, W; reads 0.
  - 4 BLINK_EN, R/W, DATA_WIDTH bits.
  - 5 PERIOD, R/W, PRESC_WIDTH bits.
  - 6 STATUS, R; bit0 = phase, bits [31:1] = 0.
  - 7 reserved; reads 0, writes ignored.
- Write effects on DATA:
  - SET: data <= data | wd.
  - CLEAR: data <= data & ~wd.
  - TOGGLE: data <= data ^ wd.
  - All take effect at the clock edge of the write cycle.
- Reset values:
  - data = RESET_VALUE, blink_en = 0, period = 0, cnt = 0, phase = 1.
  - out_port = RESET_VALUE (low DATA_WIDTH bits), not 0.
  - readdata is combinational; it reflects the reset register values.
- Prescaler, evaluated every cycle:
  - If period == 0: cnt holds 0, phase forced to 1 (blinking frozen, blinking bits steady on).
  - Else if cnt == 0: cnt <= period, phase <= ~phase.
  - Else: cnt <= cnt - 1.
  - Net effect: phase toggles every period+1 cycles.
- Any write to PERIOD loads cnt <= new value and phase <= 1 on that edge; this overrides the prescaler update in the same cycle.
- Output, registered: out_port <= data & ~(blink_en & {DATA_WIDTH{~phase}}).
- Latency:
  - A register write at edge N appears on out_port at edge N+1.
  - Readback of DATA, BLINK_EN and PERIOD is visible in the cycle after the write edge.
- Only one register is addressed per cycle, so simultaneous SET/CLEAR cannot occur. A write and a prescaler toggle in the same cycle are independent, except for a PERIOD write as above.
- Reads have no side effects; wait-state free; the read mux uses the registered state.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). The first update after deassertion occurs on the next rising clk.

Test Plan:
- Reset with RESET_VALUE=32'h0000_00A5, DATA_WIDTH=8 -> out_port=8'hA5 during and after reset; readdata at addr 0 = 32'h0000_00A5; addr 6 = 1.
- Write DATA=8'h0F, then SET 8'hF0, CLEAR 8'h03, TOGGLE 8'h81:
  - out_port sequence = 0F, FF, FC, 7D, each one cycle after its write.
  - Reads at addrs 1-3 return 0.
- DATA=8'hFF, BLINK_EN=8'h0F, PERIOD=3:
  - out_port alternates FF (4 cycles) and F0 (4 cycles).
  - STATUS bit0 tracks phase.
- During blinking, write PERIOD=0 -> phase=1 on the next edge and stays 1; out_port=8'hFF steady.
- Write PERIOD=5 while cnt=2 and phase=0 -> cnt=5, phase=1 on that edge; next toggle occurs 6 cycles later.
- Assert reset mid-blink with data=8'h3C -> out_port returns to RESET_VALUE immediately; period and blink_en read 0 after release.

Source files
------------

// File: rtl/led_pio_blink.sv
// led_pio_blink: Avalon-MM LED output port with set/clear/toggle writes and prescaled per-bit blinking.
module led_pio_blink #(
  parameter int          DATA_WIDTH  = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          PRESC_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);
  logic [DATA_WIDTH-1:0]  data_q, data_d, blink_q, blink_d, out_q, out_d, wd;
  logic [PRESC_WIDTH-1:0] period_q, period_d, cnt_q, cnt_d;
  logic                   phase_q, phase_d, wr, unused_wd;
  assign wr = chipselect & ~write_n;
  assign wd = writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^writedata;
  always_comb begin
    data_d   = !wr               ? data_q :
               address == 3'd0   ? wd :
               address == 3'd1   ? data_q | wd :
               address == 3'd2   ? data_q & ~wd :
               address == 3'd3   ? data_q ^ wd : data_q;
    blink_d  = (wr && address == 3'd4) ? wd : blink_q;
    period_d = (wr && address == 3'd5) ? writedata[PRESC_WIDTH-1:0] : period_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    // A PERIOD write restarts the prescaler with phase on, taking priority.
    if (wr && address == 3'd5) begin
      cnt_d   = writedata[PRESC_WIDTH-1:0];
      phase_d = 1'b1;
    end else if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == '0) begin
      cnt_d   = period_q;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q - PRESC_WIDTH'(1);
    end
    out_d    = data_q & ~(blink_q & {DATA_WIDTH{~phase_q}});
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= RESET_VALUE[DATA_WIDTH-1:0];
      blink_q  <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      out_q    <= RESET_VALUE[DATA_WIDTH-1:0];
    end else begin
      data_q   <= data_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      out_q    <= out_d;
    end
  end
  always_comb begin
    readdata = address == 3'd0 ? 32'(data_q) :
               address == 3'd4 ? 32'(blink_q) :
               address == 3'd5 ? 32'(period_q) :
               address == 3'd6 ? 32'(phase_q) : 32'h0;
  end
  assign out_port = out_q;
endmodule
